// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two valid/ready requesters.
// Operands are registered at issue, the result and flags are registered for the response.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int FLAG_W = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [1:0]        REQ_VALID,
  output logic [1:0]        REQ_READY,
  input  logic [WIDTH-1:0]  REQ0_A,
  input  logic [WIDTH-1:0]  REQ0_B,
  input  logic [1:0]        REQ0_CTRL,
  input  logic [WIDTH-1:0]  REQ1_A,
  input  logic [WIDTH-1:0]  REQ1_B,
  input  logic [1:0]        REQ1_CTRL,
  output logic [1:0]        RSP_VALID,
  input  logic [1:0]        RSP_READY,
  output logic [WIDTH-1:0]  RSP_RESULT,
  output logic [FLAG_W-1:0] RSP_FLAGS,
  output logic [WIDTH-1:0]  ALU_SRC_A,
  output logic [WIDTH-1:0]  ALU_SRC_B,
  output logic [1:0]        ALU_CTRL,
  input  logic [WIDTH-1:0]  ALU_RESULT,
  input  logic [FLAG_W-1:0] ALU_FLAGS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [1:0]        grant_s;
  logic              rsp_done_s;
  logic              owner_r;
  logic              last_grant_r;
  logic [WIDTH-1:0]  op_a_r;
  logic [WIDTH-1:0]  op_b_r;
  logic [1:0]        op_ctrl_r;
  logic [WIDTH-1:0]  rsp_result_r;
  logic [FLAG_W-1:0] rsp_flags_r;
  logic [1:0]        rsp_valid_r;

  // Arbitration: on contention the requester that did not win last time goes next
  always_comb begin
    grant_s = 2'b00;
    if (RESETn && (state_r == ST_IDLE)) begin
      case (REQ_VALID)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign rsp_done_s = RSP_READY[owner_r];

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s != 2'b00) next_state_s = ST_EXEC;
        else                  next_state_s = ST_IDLE;
      end
      ST_EXEC: next_state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_done_s) next_state_s = ST_IDLE;
        else            next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESETn) state_r <= ST_IDLE;
    else         state_r <= next_state_s;
  end

  // Issue: capture the winner's operands and remember it for fairness
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      op_a_r       <= {WIDTH{1'b0}};
      op_b_r       <= {WIDTH{1'b0}};
      op_ctrl_r    <= 2'b00;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (grant_s != 2'b00) begin
      op_a_r       <= grant_s[1] ? REQ1_A    : REQ0_A;
      op_b_r       <= grant_s[1] ? REQ1_B    : REQ0_B;
      op_ctrl_r    <= grant_s[1] ? REQ1_CTRL : REQ0_CTRL;
      owner_r      <= grant_s[1];
      last_grant_r <= grant_s[1];
    end
  end

  // Response: capture ALU output in EXEC, hold it until the owner consumes it
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_flags_r  <= {FLAG_W{1'b0}};
      rsp_valid_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_EXEC: begin
          rsp_result_r <= ALU_RESULT;
          rsp_flags_r  <= ALU_FLAGS;
          rsp_valid_r  <= owner_r ? 2'b10 : 2'b01;
        end
        ST_RESP: begin
          if (rsp_done_s) rsp_valid_r <= 2'b00;
        end
        default: rsp_valid_r <= 2'b00;
      endcase
    end
  end

  assign REQ_READY  = grant_s;
  assign RSP_VALID  = rsp_valid_r;
  assign RSP_RESULT = rsp_result_r;
  assign RSP_FLAGS  = rsp_flags_r;
  assign ALU_SRC_A  = op_a_r;
  assign ALU_SRC_B  = op_b_r;
  assign ALU_CTRL   = op_ctrl_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, arbitration model and response scoreboard
// with a separate monitor; directed scenarios followed by randomized traffic.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic [1:0]    REQ_VALID, REQ_READY, RSP_VALID, RSP_READY;
  logic [W-1:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [1:0]    REQ0_CTRL, REQ1_CTRL, ALU_CTRL;
  logic [W-1:0]  RSP_RESULT, ALU_SRC_A, ALU_SRC_B, ALU_RESULT;
  logic [3:0]    RSP_FLAGS, ALU_FLAGS;

  always #5 CLK = ~CLK;

  alu_share_arbiter #(.WIDTH(W), .FLAG_W(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_CTRL(REQ0_CTRL),
    .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_CTRL(REQ1_CTRL),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RESULT(RSP_RESULT), .RSP_FLAGS(RSP_FLAGS),
    .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_CTRL(ALU_CTRL),
    .ALU_RESULT(ALU_RESULT), .ALU_FLAGS(ALU_FLAGS)
  );

  // Arithmetic definition of the ALU: returns {result, N, Z, C, V}
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cf, vf;
    s = 33'd0; cf = 1'b0; vf = 1'b0;
    case (c)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cf = s[32];
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cf = s[32];
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r, r[31], (r == 32'd0), cf, vf};
  endfunction

  assign {ALU_RESULT, ALU_FLAGS} = alu_ref(ALU_SRC_A, ALU_SRC_B, ALU_CTRL);

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] res;
    logic [3:0]  flg;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycle = 0;
  bit   in_flight = 1'b0;
  bit   exp_last = 1'b1;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One cycle of stimulus: drive, predict the grant, record the expected response
  task automatic step(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [1:0] c0, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] c1, input logic [1:0] rr);
    logic [1:0]  g;
    logic [35:0] e;
    exp_t        item;
    REQ_VALID = v; RSP_READY = rr;
    REQ0_A = a0; REQ0_B = b0; REQ0_CTRL = c0;
    REQ1_A = a1; REQ1_B = b1; REQ1_CTRL = c1;
    #1;
    g = 2'b00;
    if (!in_flight) begin
      if (v == 2'b11)      g = exp_last ? 2'b01 : 2'b10;
      else                 g = v;
    end
    check("req_ready", REQ_READY, g);
    if (g != 2'b00) begin
      e = g[1] ? alu_ref(a1, b1, c1) : alu_ref(a0, b0, c0);
      item.owner = g; item.res = e[35:4]; item.flg = e[3:0]; item.due = cycle + 2;
      sb_q.push_back(item);
      in_flight = 1'b1;
      exp_last = g[1];
    end
    @(posedge CLK); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 2'b00, 2'b11);
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    REQ_VALID = 2'b00; RSP_READY = 2'b00;
    sb_q.delete(); in_flight = 1'b0; exp_last = 1'b1;
    #1;
    check("ready_in_reset", REQ_READY, 2'b00);
    @(posedge CLK); #2;
    check("rst_rsp_valid", RSP_VALID, 2'b00);
    check("rst_result", RSP_RESULT, 32'd0);
    check("rst_flags", RSP_FLAGS, 4'd0);
    check("rst_src_a", ALU_SRC_A, 32'd0);
    check("rst_src_b", ALU_SRC_B, 32'd0);
    check("rst_ctrl", ALU_CTRL, 2'd0);
    RESETn = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares each presented response against the scoreboard head
  initial begin
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESETn) begin
        prev_valid = 1'b0;
      end else if (sb_q.size() == 0) begin
        check("rsp_valid_unexpected", RSP_VALID, 2'b00);
        prev_valid = (RSP_VALID != 2'b00);
      end else begin
        if (RSP_VALID != 2'b00) begin
          if (!prev_valid) check("latency", cycle, sb_q[0].due);
          check("rsp_owner", RSP_VALID, sb_q[0].owner);
          check("rsp_result", RSP_RESULT, sb_q[0].res);
          check("rsp_flags", RSP_FLAGS, sb_q[0].flg);
          if ((sb_q[0].owner & RSP_READY) != 2'b00) begin
            void'(sb_q.pop_front());
            in_flight = 1'b0;
          end
        end else if (cycle > sb_q[0].due) begin
          check("rsp_timeout", RSP_VALID, sb_q[0].owner);
          void'(sb_q.pop_front());
          in_flight = 1'b0;
        end
        prev_valid = (RSP_VALID != 2'b00);
      end
    end
  end

  initial begin
    RESETn = 1'b0; REQ_VALID = 2'b00; RSP_READY = 2'b00;
    REQ0_A = 32'd0; REQ0_B = 32'd0; REQ0_CTRL = 2'b00;
    REQ1_A = 32'd0; REQ1_B = 32'd0; REQ1_CTRL = 2'b00;
    @(posedge CLK); #2;
    do_reset();

    step(2'b01, 32'd5, 32'd3, 2'b00, 32'd0, 32'd0, 2'b00, 2'b11); idle(3);
    step(2'b10, 32'd0, 32'd0, 2'b00, 32'd3, 32'd5, 2'b01, 2'b11); idle(3);
    step(2'b01, 32'd7, 32'd7, 2'b01, 32'd0, 32'd0, 2'b00, 2'b11); idle(3);

    for (int i = 0; i < 12; i++)
      step(2'b11, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), 2'b11);
    idle(3);

    // Response stalled while both keep requesting; non-owner ready alone must not release it
    step(2'b01, 32'd100, 32'd23, 2'b01, 32'd1, 32'd2, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++)
      step(2'b11, 32'd9, 32'd9, 2'b00, 32'd4, 32'd4, 2'b00, 2'b10);
    step(2'b11, 32'd9, 32'd9, 2'b00, 32'd4, 32'd4, 2'b00, 2'b11); idle(4);

    step(2'b01, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'd0, 32'd0, 2'b00, 2'b11); idle(3);
    step(2'b01, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 32'd0, 32'd0, 2'b00, 2'b11); idle(3);

    // Reset while the op sits in EXEC, after requester 0 won last
    step(2'b01, 32'd9, 32'd9, 2'b00, 32'd0, 32'd0, 2'b00, 2'b11);
    do_reset();
    step(2'b11, 32'd1, 32'd2, 2'b00, 32'd3, 32'd4, 2'b00, 2'b11); idle(3);

    for (int i = 0; i < 400; i++)
      step(2'($urandom), pick(), pick(), 2'($urandom), pick(), pick(), 2'($urandom),
           2'($urandom));
    idle(6);
    check("drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
